// File: rtl/serial_receiver.sv
// serial_receiver: UART-style receiver. The serial line is synchronised, the
// start bit is qualified at its centre, DATA_BITS are shifted in LSB-first and
// the stop bit is checked. Each byte is held on a valid/ready handshake.
// Optional feature macro: PARITY_CHECK_EN adds one even-parity bit after the
// data bits and a parity_error pulse output.
module serial_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun_error
`ifdef PARITY_CHECK_EN
    ,
    output logic                 parity_error
`endif
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_CHECK_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 fe_q, fe_d;
    logic                 oe_q, oe_d;
    logic                 deliver;
    logic                 baud_last;
`ifdef PARITY_CHECK_EN
    logic                 par_q, par_d;
    logic                 pe_q, pe_d;
`endif

    assign baud_last = (baud_q == FULL_LAST);

    // Next-state logic for the frame FSM, the deserialiser and the output handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        fe_d       = 1'b0;
        oe_d       = 1'b0;
        deliver    = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d      = par_q;
        pe_d       = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_cnt_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                // Half a bit in: a high line means the falling edge was a glitch.
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    // Shift right so the first (LSB) bit ends up in bit 0.
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_sync_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    par_d   = rx_sync_q;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
`ifdef PARITY_CHECK_EN
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if ((^shift_q) ^ par_q) pe_d = 1'b1;
                        else                    deliver = 1'b1;
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        // A low stop bit reports framing only, whatever the parity.
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is not taken as a new start bit.
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Consumer handshake; a completing byte either loads or overruns.
        if (valid_q && data_ready) valid_d = 1'b0;
        if (deliver) begin
            if (valid_q && !data_ready) begin
                oe_d = 1'b1;
            end else begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset returns everything to the idle line state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the shift register is reset too so a discarded partial byte never leaks out.
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q      <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            rx_meta_q  <= rx_serial;
            rx_sync_q  <= rx_meta_q;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
`ifdef PARITY_CHECK_EN
            par_q      <= par_d;
            pe_q       <= pe_d;
`endif
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = valid_q;
    assign busy          = busy_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;
`ifdef PARITY_CHECK_EN
    assign parity_error  = pe_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed bench for serial_receiver at CLKS_PER_BIT=16,
// DATA_BITS=8. A table of frames plus hand-written corner sequences
// (held data, break, glitch, mid-frame reset, parity when PARITY_CHECK_EN).
module tb_serial_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       framing_error;
    logic       overrun_error;
`ifdef PARITY_CHECK_EN
    logic       parity_error;
`endif

    int total = 0;
    int bad   = 0;

    // Event counters, updated on the falling edge away from the active edge.
    int   rise_cnt = 0;
    int   fe_cnt   = 0;
    int   oe_cnt   = 0;
    int   pe_cnt   = 0;
    logic valid_prev = 1'b0;

    serial_receiver #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .rx_serial    (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
`ifdef PARITY_CHECK_EN
        ,
        .parity_error (parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid && !valid_prev) rise_cnt++;
        if (framing_error) fe_cnt++;
        if (overrun_error) oe_cnt++;
`ifdef PARITY_CHECK_EN
        if (parity_error) pe_cnt++;
`endif
        valid_prev = data_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the n-th next falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One frame; rx is left at the stop-bit level for the caller to release.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef PARITY_CHECK_EN
        rx = (^d) ^ par_flip;
        tick(CPB);
`else
        if (par_flip) rx = 1'b1; // no parity bit in this build
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ready;
        logic       stop_bit;
        int         exp_rise;
        int         exp_fe;
        int         exp_oe;
        logic [7:0] exp_dout;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0, f0, o0, p0, low_busy;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'h11, 1'b0, 1'b1, 1, 0, 0, 8'h11, 1'b1};
        vecs[2] = '{8'h22, 1'b0, 1'b1, 0, 0, 1, 8'h11, 1'b1};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 1, 0, 0, 8'hC3, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 0, 1, 0, 8'hC3, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF, 1'b0};

        rx = 1'b1;
        data_ready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("reset data_out", data_out, 0);
        check("reset data_valid", data_valid, 0);
        check("reset busy", busy, 0);
        check("reset framing_error", framing_error, 0);
        check("reset overrun_error", overrun_error, 0);
        rst_n = 1'b1;
        tick(4);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            r0 = rise_cnt; f0 = fe_cnt; o0 = oe_cnt;
            data_ready = vecs[i].ready;
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
            rx = 1'b1;
            tick(8);
            check($sformatf("v%0d valid rises", i), rise_cnt - r0, vecs[i].exp_rise);
            check($sformatf("v%0d framing", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("v%0d overrun", i), oe_cnt - o0, vecs[i].exp_oe);
            check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_dout);
            check($sformatf("v%0d data_valid", i), data_valid, vecs[i].exp_valid);
            check($sformatf("v%0d busy", i), busy, 0);
        end

        // Byte held until the consumer accepts it.
        data_ready = 1'b0;
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        tick(4);
        check("hold rises", rise_cnt - r0, 1);
        tick(20);
        check("hold data_valid", data_valid, 1);
        check("hold data_out", data_out, 8'h3C);
        data_ready = 1'b1;
        tick(1);
        check("accept data_valid", data_valid, 0);
        check("accept data_out kept", data_out, 8'h3C);

        // Low stop bit followed by a held-low line.
        r0 = rise_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        low_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!busy) low_busy++;
        end
        check("break busy low cycles", low_busy, 0);
        check("break framing", fe_cnt - f0, 1);
        rx = 1'b1;
        tick(6);
        check("break release busy", busy, 0);
        tick(20);
        check("break no valid", rise_cnt - r0, 0);

        // Short low glitch on an idle line.
        r0 = rise_cnt; f0 = fe_cnt; o0 = oe_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(25);
        check("glitch busy", busy, 0);
        check("glitch events", (rise_cnt - r0) + (fe_cnt - f0) + (oe_cnt - o0), 0);

        // Reset during bit 3 of a frame, then a clean frame.
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = i[0] ? 1'b1 : 1'b0;
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        tick(1);
        check("mid reset data_out", data_out, 0);
        check("mid reset busy", busy, 0);
        check("mid reset data_valid", data_valid, 0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        r0 = rise_cnt;
        data_ready = 1'b0;
        send_frame(8'h7E, 1'b1, 1'b0);
        rx = 1'b1;
        tick(4);
        check("post reset rises", rise_cnt - r0, 1);
        check("post reset data_out", data_out, 8'h7E);
        data_ready = 1'b1;
        tick(2);

`ifdef PARITY_CHECK_EN
        // Even parity: 0x07 needs parity bit 1.
        r0 = rise_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        tick(8);
        check("parity ok rises", rise_cnt - r0, 1);
        check("parity ok data_out", data_out, 8'h07);
        check("parity ok no error", pe_cnt - p0, 0);
        r0 = rise_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        tick(8);
        check("parity bad error", pe_cnt - p0, 1);
        check("parity bad rises", rise_cnt - r0, 0);
        r0 = rise_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        rx = 1'b1;
        tick(8);
        check("parity+stop0 framing", fe_cnt - f0, 1);
        check("parity+stop0 no parity", pe_cnt - p0, 0);
`else
        p0 = pe_cnt;
        check("no parity events", pe_cnt - p0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
